// File: rtl/unpacker_arb.sv
// unpacker_arb: packet-granular round-robin arbiter that shares one unpacker
// between N_SRC beat sources. A source is granted on a valid sop beat, keeps
// the grant until its eop beat is accepted, then the arbiter spends one idle
// cycle re-arbitrating starting after the source that was served last.
module unpacker_arb #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 1280,
  parameter int VBC_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic [N_SRC-1:0]           s_val,
  input  logic [N_SRC-1:0]           s_sop,
  input  logic [N_SRC-1:0]           s_eop,
  input  logic [N_SRC*VBC_W-1:0]     s_vbc,
  input  logic [N_SRC*DATA_W-1:0]    s_data,
  output logic [N_SRC-1:0]           s_ready,
  output logic                       u_val,
  output logic                       u_sop,
  output logic                       u_eop,
  output logic [VBC_W-1:0]           u_vbc,
  output logic [DATA_W-1:0]          u_data,
  input  logic                       u_ready,
  output logic [$clog2(N_SRC)-1:0]   gnt,
  output logic                       busy,
  output logic                       orphan_err,
  output logic [CNT_W-1:0]           pkt_cnt
);

  localparam int GW = $clog2(N_SRC);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [GW-1:0]      r_gnt;
  logic [GW-1:0]      r_last_gnt;
  logic [CNT_W-1:0]   r_pkt_cnt;
  logic               r_orphan_err;

  logic [N_SRC-1:0]   w_req;
  logic [N_SRC-1:0]   w_orphan;
  logic [GW-1:0]      w_pick;
  logic               w_pick_vld;
  logic               w_eop_xfer;
  logic               w_sel_val;
  logic               w_sel_sop;
  logic               w_sel_eop;
  logic [VBC_W-1:0]   w_sel_vbc;
  logic [DATA_W-1:0]  w_sel_data;

  assign w_req    = s_val & s_sop;
  assign w_orphan = s_val & ~s_sop;

  // Select the granted source's beat fields.
  always_comb begin
    w_sel_val  = s_val[r_gnt];
    w_sel_sop  = s_sop[r_gnt];
    w_sel_eop  = s_eop[r_gnt];
    w_sel_vbc  = s_vbc[int'(r_gnt)*VBC_W +: VBC_W];
    w_sel_data = s_data[int'(r_gnt)*DATA_W +: DATA_W];
  end

  // Round-robin pick: first requesting index after the last served source.
  always_comb begin
    int unsigned v_idx;
    v_idx      = 0;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      v_idx = (32'(r_last_gnt) + k) % N_SRC;
      if (!w_pick_vld && w_req[v_idx]) begin
        w_pick_vld = 1'b1;
        w_pick     = GW'(v_idx);
      end
    end
  end

  // Next state, beat forwarding and ready steering; handshakes held low in reset.
  always_comb begin
    w_state_nxt = r_state;
    s_ready     = '0;
    u_val       = 1'b0;
    u_sop       = 1'b0;
    u_eop       = 1'b0;
    u_vbc       = '0;
    u_data      = w_sel_data;
    w_eop_xfer  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s_ready = w_orphan;
        if (w_pick_vld) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        u_val          = w_sel_val;
        u_sop          = w_sel_sop;
        u_eop          = w_sel_eop;
        u_vbc          = w_sel_vbc;
        s_ready[r_gnt] = u_ready;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!reset_L) begin
      s_ready = '0;
      u_val   = 1'b0;
      u_sop   = 1'b0;
      u_eop   = 1'b0;
    end
    w_eop_xfer = u_val && u_ready && u_eop;
    if (r_state == ST_BUSY && w_eop_xfer) w_state_nxt = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Grant, round-robin pointer, packet counter and orphan pulse.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_gnt        <= '0;
      r_last_gnt   <= GW'(N_SRC - 1);
      r_pkt_cnt    <= '0;
      r_orphan_err <= 1'b0;
    end else begin
      r_orphan_err <= (r_state == ST_IDLE) && (|w_orphan);
      if (r_state == ST_IDLE && w_pick_vld) r_gnt <= w_pick;
      if (w_eop_xfer) begin
        r_pkt_cnt  <= r_pkt_cnt + 1'b1;
        r_last_gnt <= r_gnt;
      end
    end
  end

  assign gnt        = r_gnt;
  assign busy       = (r_state == ST_BUSY);
  assign orphan_err = r_orphan_err;
  assign pkt_cnt    = r_pkt_cnt;

endmodule

// File: tb/tb_unpacker_arb.sv
// Scoreboard bench for unpacker_arb: per-source packet queues feed a driver;
// a monitor applies round-robin-over-pending-packets rules to predict grants
// and pops expected beats whenever a transfer is presented.
module tb_unpacker_arb;

  localparam int N  = 4;
  localparam int DW = 1280;
  localparam int VW = 8;
  localparam int CW = 8;
  localparam int GW = $clog2(N);

  typedef struct {
    bit            sop;
    bit            eop;
    logic [VW-1:0] vbc;
    logic [DW-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset_L = 1'b0;
  logic [N-1:0]      s_val, s_sop, s_eop, s_ready;
  logic [N*VW-1:0]   s_vbc;
  logic [N*DW-1:0]   s_data;
  logic              u_val, u_sop, u_eop, u_ready;
  logic [VW-1:0]     u_vbc;
  logic [DW-1:0]     u_data;
  logic [GW-1:0]     gnt;
  logic              busy, orphan_err;
  logic [CW-1:0]     pkt_cnt;

  unpacker_arb #(.N_SRC(N), .DATA_W(DW), .VBC_W(VW), .CNT_W(CW)) dut (
    .clk(clk), .reset_L(reset_L),
    .s_val(s_val), .s_sop(s_sop), .s_eop(s_eop), .s_vbc(s_vbc), .s_data(s_data),
    .s_ready(s_ready),
    .u_val(u_val), .u_sop(u_sop), .u_eop(u_eop), .u_vbc(u_vbc), .u_data(u_data),
    .u_ready(u_ready),
    .gnt(gnt), .busy(busy), .orphan_err(orphan_err), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  beat_t src_q [N][$];
  beat_t exp_q [N][$];

  bit           drv_en = 1'b0;
  bit           gap_en = 1'b0;
  int           rdy_mode = 0;   // 0: always ready, 1: random, 2: man_ready
  logic         man_ready = 1'b1;
  logic [N-1:0] man_val = '1;
  logic [N-1:0] man_sop = '1;
  logic [N-1:0] acc = '0;

  bit mon_en = 1'b1;
  bit m_busy = 1'b0;
  int m_gnt  = 0;
  int m_last = N - 1;
  int m_cnt  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual[63:0]=%0h required[63:0]=%0h t=%0t", nm, act[63:0], exp[63:0], $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    d = '0;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  // Called right at a posedge so driver and model see the packet together.
  task automatic push_pkt(input int src, input int nb, input int last_vbc);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.sop  = (k == 0);
      b.eop  = (k == nb - 1);
      b.vbc  = (k == nb - 1) ? VW'(last_vbc) : VW'(160);
      b.data = rnd_data();
      src_q[src].push_back(b);
      exp_q[src].push_back(b);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    while (n < budget && !(all_empty() && !m_busy)) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, 64'(all_empty() && !m_busy), 64'd1);
  endtask

  // Source driver: presents each source's head beat; sop beats are always valid.
  always @(posedge clk) begin
    beat_t b;
    #1;
    if (drv_en)
      for (int i = 0; i < N; i++)
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    for (int i = 0; i < N; i++) begin
      s_val[i] = 1'b0;
      s_sop[i] = 1'b0;
      s_eop[i] = 1'b0;
      s_vbc[i*VW +: VW] = '0;
      if (drv_en) begin
        if (src_q[i].size() > 0) begin
          b = src_q[i][0];
          s_val[i] = b.sop || !gap_en || ($urandom_range(0, 3) != 0);
          s_sop[i] = b.sop;
          s_eop[i] = b.eop;
          s_vbc[i*VW +: VW] = b.vbc;
          s_data[i*DW +: DW] = b.data;
        end
      end else begin
        s_val[i] = man_val[i];
        s_sop[i] = man_sop[i];
      end
    end
    case (rdy_mode)
      0:       u_ready = 1'b1;
      1:       u_ready = ($urandom_range(0, 3) != 0);
      default: u_ready = man_ready;
    endcase
  end

  always @(negedge clk) acc = s_ready & s_val;

  // Monitor / reference model.
  always @(negedge clk) begin
    beat_t        b;
    logic [N-1:0] er;
    bit           found;
    int           idx;
    if (reset_L && mon_en) begin
      if (!m_busy) begin
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_uval", 64'(u_val), 64'd0);
        chk("idle_ready", 64'(s_ready), 64'(s_val & ~s_sop));
        chk("idle_pkt_cnt", 64'(pkt_cnt), 64'(m_cnt % (1 << CW)));
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (!found && exp_q[idx].size() > 0) begin
            found = 1'b1;
            m_gnt = idx;
          end
        end
        if (found) m_busy = 1'b1;
      end else begin
        chk("busy", 64'(busy), 64'd1);
        chk("gnt", 64'(gnt), 64'(m_gnt));
        chk("u_val_mux", 64'(u_val), 64'(s_val[m_gnt]));
        er = '0;
        if (u_ready) er[m_gnt] = 1'b1;
        chk("busy_ready", 64'(s_ready), 64'(er));
        if (u_val && u_ready) begin
          if (exp_q[m_gnt].size() == 0) begin
            chk("beat_unexpected", 64'd1, 64'd0);
          end else begin
            b = exp_q[m_gnt].pop_front();
            chk("u_sop", 64'(u_sop), 64'(b.sop));
            chk("u_eop", 64'(u_eop), 64'(b.eop));
            chk("u_vbc", 64'(u_vbc), 64'(b.vbc));
            chk_data("u_data", u_data, b.data);
            chk("xfer_pkt_cnt", 64'(pkt_cnt), 64'(m_cnt % (1 << CW)));
            if (b.eop) begin
              m_busy = 1'b0;
              m_last = m_gnt;
              m_cnt++;
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    int need;
    logic [DW-1:0] hold_data;

    // Reset with every source requesting.
    rdy_mode = 0;
    man_val  = '1;
    man_sop  = '1;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_u_val", 64'(u_val), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_orphan", 64'(orphan_err), 64'd0);

    // Four single-beat packets: served 0,1,2,3.
    @(posedge clk);
    drv_en = 1'b1;
    for (int i = 0; i < N; i++) push_pkt(i, 1, 100);
    #2 reset_L = 1'b1;
    wait_drain("rr4", 200);
    @(posedge clk);
    @(negedge clk);
    chk("rr4_pkt_cnt", 64'(pkt_cnt), 64'd4);

    // Source 2 three-beat packet, source 1 requests mid-packet.
    @(posedge clk);
    push_pkt(2, 3, 40);
    n = 0;
    while (n < 100 && !(m_busy && m_gnt == 2)) begin
      @(posedge clk);
      n++;
    end
    chk("mid_req_grant2", 64'(m_busy && m_gnt == 2), 64'd1);
    push_pkt(1, 2, 77);
    wait_drain("mid_req", 200);

    // Five-cycle u_ready stall in the middle of a packet.
    @(posedge clk);
    push_pkt(0, 3, 33);
    n = 0;
    while (n < 100 && exp_q[0].size() != 2) begin
      @(posedge clk);
      n++;
    end
    chk("stall_setup", 64'(exp_q[0].size()), 64'd2);
    hold_data = exp_q[0][0].data;
    rdy_mode  = 2;
    man_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_u_val", 64'(u_val), 64'd1);
      chk("stall_u_sop", 64'(u_sop), 64'd0);
      chk("stall_u_vbc", 64'(u_vbc), 64'd160);
      chk("stall_s_ready", 64'(s_ready), 64'd0);
      chk_data("stall_u_data", u_data, hold_data);
    end
    @(posedge clk);
    rdy_mode = 0;
    wait_drain("stall", 200);

    // Orphan beat on source 3 while idle.
    @(posedge clk);
    drv_en  = 1'b0;
    man_val = '0;
    man_sop = '0;
    @(posedge clk);
    man_val = 4'b1000;
    @(negedge clk);
    chk("orphan_s_ready", 64'(s_ready), 64'b1000);
    chk("orphan_u_val", 64'(u_val), 64'd0);
    @(posedge clk);
    man_val = '0;
    @(negedge clk);
    chk("orphan_pulse", 64'(orphan_err), 64'd1);
    @(negedge clk);
    chk("orphan_pulse_end", 64'(orphan_err), 64'd0);
    chk("orphan_pkt_cnt", 64'(pkt_cnt), 64'(m_cnt % (1 << CW)));
    @(posedge clk);
    drv_en = 1'b1;

    // Only source 1 requesting: back-to-back packets with one idle bubble.
    @(posedge clk);
    for (int p = 0; p < 4; p++) push_pkt(1, $urandom_range(1, 3), $urandom_range(1, 160));
    wait_drain("solo", 400);

    // Randomised traffic with beat gaps and ready back-pressure.
    gap_en   = 1'b1;
    rdy_mode = 1;
    for (int r = 0; r < 4; r++) begin
      @(posedge clk);
      for (int i = 0; i < N; i++)
        for (int p = $urandom_range(0, 3); p > 0; p--)
          push_pkt(i, $urandom_range(1, 4), $urandom_range(1, 160));
      repeat ($urandom_range(3, 15)) @(posedge clk);
      push_pkt($urandom_range(0, N - 1), $urandom_range(1, 4), $urandom_range(1, 160));
      wait_drain("rand", 3000);
    end
    gap_en   = 1'b0;
    rdy_mode = 0;

    // Counter wrap.
    need = (1 << CW) - (m_cnt % (1 << CW));
    @(posedge clk);
    for (int p = 0; p < need; p++) push_pkt($urandom_range(0, N - 1), 1, 1);
    wait_drain("wrap", 5000);
    @(posedge clk);
    @(negedge clk);
    chk("wrap_pkt_cnt", 64'(pkt_cnt), 64'd0);

    // Reset in the middle of a packet.
    @(posedge clk);
    push_pkt(2, 3, 50);
    n = 0;
    while (n < 100 && !(m_busy && exp_q[2].size() == 2)) begin
      @(posedge clk);
      n++;
    end
    chk("rstmid_setup", 64'(m_busy), 64'd1);
    #3 reset_L = 1'b0;
    #1;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_gnt", 64'(gnt), 64'd0);
    chk("rstmid_s_ready", 64'(s_ready), 64'd0);
    chk("rstmid_u_val", 64'(u_val), 64'd0);
    chk("rstmid_pkt_cnt", 64'(pkt_cnt), 64'd0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    m_busy = 1'b0;
    m_last = N - 1;
    m_cnt  = 0;
    @(posedge clk);
    @(posedge clk);
    for (int i = N - 1; i >= 0; i--) push_pkt(i, 1, 100);
    #2 reset_L = 1'b1;
    wait_drain("post_rst", 200);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
